// File: rtl/control_sequencer.sv
// Instruction-cycle control sequencer: fetch (T0-T2), decode/execute (T3-T6) and halt.
// Strobes are Moore outputs decoded from the present state and the opcode field of IR.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic [4:0]  alu_op,
  output logic        halted,
  output logic        illegal
);

  localparam int unsigned OPC_W  = 5;
  localparam int unsigned OPC_LO = 27;

  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  state_t           state_q;
  state_t           state_d;
  state_t           end_state;
  logic [OPC_W-1:0] opcode;
  logic             is_muldiv;
  logic             is_alu;

  // Register fields ra/rb/rc are consumed by the datapath's register select, not here.
  logic unused_ir;
  assign unused_ir = ^IR[OPC_LO-1:0];

  assign opcode    = IR[OPC_LO +: OPC_W];
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_alu    = (opcode <= OP_ROL) || is_muldiv;
  assign end_state = run ? T0 : IDLE;

  always_ff @(posedge clock) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = '0;
    halted   = 1'b0;
    illegal  = 1'b0;

    unique case (state_q)
      IDLE: if (run) state_d = T0;
      T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zlowin  = 1'b1;
        state_d = T1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (mem_ready) state_d = T2;
      end
      T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = T3;
      end
      // First cycle with the freshly loaded IR: dispatch on opcode class.
      T3: begin
        if (is_alu) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = T4;
        end else if (opcode == OP_NOP) begin
          state_d = end_state;
        end else if (opcode == OP_HALT) begin
          state_d = HALT;
        end else begin
          illegal = 1'b1;
          state_d = end_state;
        end
      end
      T4: begin
        Grc     = 1'b1;
        Rout    = 1'b1;
        Zlowin  = 1'b1;
        Zhighin = is_muldiv;
        alu_op  = opcode;
        state_d = T5;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin    = 1'b1;
          state_d = T6;
        end else begin
          Gra     = 1'b1;
          Rin     = 1'b1;
          state_d = end_state;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        state_d  = end_state;
      end
      HALT: halted = 1'b1;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed scenarios plus randomized run/mem_ready/IR/clear,
// checked every cycle against an instruction-step model of the sequencer.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear;
  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin;
  logic        Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin;
  logic        Gra, Grb, Grc, Rin, Rout;
  logic [4:0]  alu_op;
  logic        halted;
  logic        illegal;

  int vectors = 0;
  int errors  = 0;
  // Model position: -1 idle, 0..6 = step Tn of the instruction, 7 halted.
  int m_step  = -1;

  localparam int STEP_IDLE = -1;
  localparam int STEP_HALT = 7;

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
    .Rout(Rout), .alu_op(alu_op), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  function automatic int op_of(input logic [31:0] ir);
    return int'(ir[31:27]);
  endfunction

  function automatic bit op_muldiv(input int op);
    return (op == 15) || (op == 16);
  endfunction

  function automatic bit op_alu(input int op);
    return (op <= 8) || op_muldiv(op);
  endfunction

  // Index of the final step of an instruction, by opcode class.
  function automatic int last_step(input int op);
    if (op_muldiv(op)) return 6;
    if (op_alu(op))    return 5;
    return 3;
  endfunction

  function automatic int model_next(input int st, input logic c, input logic r,
                                    input logic m, input logic [31:0] ir);
    int op;
    op = op_of(ir);
    if (c)                     return STEP_IDLE;
    if (st == STEP_HALT)       return STEP_HALT;
    if (st == STEP_IDLE)       return r ? 0 : STEP_IDLE;
    if (st == 1 && !m)         return 1;
    if (st == last_step(op))   return (op == 27) ? STEP_HALT : (r ? 0 : STEP_IDLE);
    return st + 1;
  endfunction

  // Expected outputs packed as {20 strobes, halted, illegal, alu_op}.
  function automatic logic [26:0] model_out(input int st, input logic [31:0] ir);
    logic pco, pci, inc, mar, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii;
    logic ga, gb, gc, ri, ro, hl, il;
    logic [4:0] aop;
    int op;
    op = op_of(ir);
    {pco, pci, inc, mar, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii} = '0;
    {ga, gb, gc, ri, ro, hl, il} = '0;
    aop = 5'd0;
    case (st)
      0: {pco, mar, inc, zli} = 4'hF;
      1: {zlo, pci, rd, mdi} = 4'hF;
      2: {mdo, iri} = 2'b11;
      3: begin
        if (op_alu(op)) {gb, ro, yi} = 3'b111;
        else if (op != 26 && op != 27) il = 1'b1;
      end
      4: begin
        {gc, ro, zli} = 3'b111;
        zhi = op_muldiv(op);
        aop = 5'(op);
      end
      5: begin
        zlo = 1'b1;
        if (op_muldiv(op)) loi = 1'b1;
        else {ga, ri} = 2'b11;
      end
      6: {zho, hii} = 2'b11;
      STEP_HALT: hl = 1'b1;
      default: ;
    endcase
    return {pco, pci, inc, mar, rd, mdi, mdo, iri, yi, zli, zhi, zlo, zho, loi, hii,
            ga, gb, gc, ri, ro, hl, il, aop};
  endfunction

  function automatic logic [26:0] dut_out();
    return {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin,
            Zlowout, Zhighout, LOin, HIin, Gra, Grb, Grc, Rin, Rout, halted, illegal, alu_op};
  endfunction

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply inputs for one clock, advance the model, then compare at the falling edge.
  task automatic cycle(input logic c, input logic r, input logic m, input logic [31:0] ir);
    int nxt;
    clear = c; run = r; mem_ready = m; IR = ir;
    nxt = model_next(m_step, c, r, m, ir);
    @(posedge clock);
    m_step = nxt;
    @(negedge clock);
    lit($sformatf("model step=%0d ir=%h", m_step, IR), 32'(dut_out()), 32'(model_out(m_step, IR)));
  endtask

  localparam logic [31:0] IR_ROR  = 32'h3891_8000;
  localparam logic [31:0] IR_MUL  = 32'h7891_8000;
  localparam logic [31:0] IR_HALT = 32'hD800_0000;
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;

  initial begin
    int cnt;
    logic [31:0] cur_ir;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = '0;

    // ror through T0..T5 and back to T0
    cycle(1, 1, 1, IR_ROR);
    lit("reset_outputs", 32'(dut_out()), 32'd0);
    cycle(0, 1, 1, IR_ROR);
    lit("t0_strobes", {28'd0, PCout, MARin, IncPC, Zlowin}, 32'hF);
    cycle(0, 1, 1, IR_ROR);
    cycle(0, 1, 1, IR_ROR);
    lit("t2_irin", {30'd0, MDRout, IRin}, 32'h3);
    cycle(0, 1, 1, IR_ROR);
    cycle(0, 1, 1, IR_ROR);
    lit("ror_t4_aluop", 32'(alu_op), 32'd7);
    lit("ror_t4_strobes", {28'd0, Grc, Rout, Zlowin, Zhighin}, 32'hE);
    cycle(0, 1, 1, IR_ROR);
    lit("ror_t5_strobes", {28'd0, Gra, Rin, Zlowout, alu_op == 5'd0}, 32'hF);
    cycle(0, 1, 1, IR_ROR);
    lit("ror_back_t0", 32'(PCout), 32'd1);

    // memory wait: three not-ready cycles in T1
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, (i == 4) ? 1'b1 : 1'b0, IR_ROR);
      cnt += int'(Read && MDRin);
    end
    lit("memwait_read_cycles", 32'(cnt), 32'd4);
    lit("memwait_t2", 32'(IRin), 32'd1);
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, IR_ROR);

    // mul: extra Zhighin, LOin, then T6
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, IR_MUL);
    lit("mul_t4_zhighin", {29'd0, Zhighin, alu_op == 5'd15, Zlowin}, 32'h7);
    cycle(0, 1, 1, IR_MUL);
    lit("mul_t5_loin", {30'd0, LOin, Rin}, 32'h2);
    cycle(0, 1, 1, IR_MUL);
    lit("mul_t6", {30'd0, Zhighout, HIin}, 32'h3);
    cycle(0, 1, 1, IR_MUL);
    lit("mul_back_t0", 32'(PCout), 32'd1);

    // halt: sticky regardless of run/mem_ready until clear
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, IR_HALT);
    lit("halt_enter", 32'(halted), 32'd1);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 1, IR_HALT);
      cnt += int'(halted);
    end
    lit("halt_sticky", 32'(cnt), 32'd10);
    cycle(1, 1, 1, IR_HALT);
    lit("halt_cleared", 32'(dut_out()), 32'd0);

    // illegal opcode: single pulse, no writeback, then next fetch
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 1, IR_ILL);
      cnt += int'(illegal);
      if (i == 3) lit("illegal_no_wb", {30'd0, Rin, Zlowin}, 32'd0);
    end
    lit("illegal_pulses", 32'(cnt), 32'd1);
    lit("illegal_next_t0", 32'(PCout), 32'd1);

    // clear during T4
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, IR_ROR);
    lit("pre_reset_t4", 32'(alu_op), 32'd7);
    cycle(1, 1, 1, IR_ROR);
    lit("reset_mid_t4", 32'(dut_out()), 32'd0);
    cycle(0, 0, 1, IR_ROR);
    lit("idle_hold", 32'(dut_out()), 32'd0);

    // randomized traffic; IR is reloaded only while the model is in T2
    cur_ir = IR_ROR;
    for (int i = 0; i < 4000; i++) begin
      logic c, r, m;
      if (m_step == 2) cur_ir = $urandom;
      c = ($urandom_range(0, 99) < 2);
      r = ($urandom_range(0, 99) < 80);
      m = 1'($urandom_range(0, 1));
      cycle(c, r, m, cur_ir);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
